operand_flit_injector: RTL

- Source side of the two-operand flit protocol used by the logic processing elements.
- Accepts operand pairs (A, B) from a local producer and buffers them in a small FIFO.
- Serialises each pair into two 71-bit data flits: operand A on vc 0, then operand B on vc 1.
- Emits the flits toward one or more destination node IDs. The downstream router or PE consumes them through a valid/accept handshake.

---
 rtl/operand_flit_injector.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/operand_flit_injector.sv
// Operand flit injector: buffers (A,B) operand pairs and serialises each
// pair into two data flits (A on vc0, B on vc1) for up to four destinations.
// Ports: clk, reset (sync, active-high); op_valid/op_a/op_b/op_ready producer
// side; output_flit1/ready_send/send_accept flit side; busy, pairs_sent status.
module operand_flit_injector #(
  parameter int         DEST_COUNT = 1,
  parameter logic [3:0] DEST0      = 4'b0110,
  parameter logic [3:0] DEST1      = 4'b0110,
  parameter logic [3:0] DEST2      = 4'b0110,
  parameter logic [3:0] DEST3      = 4'b0110,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [63:0] op_a,
  input  logic [63:0] op_b,
  output logic        op_ready,
  output logic [70:0] output_flit1,
  output logic        ready_send,
  input  logic        send_accept,
  output logic        busy,
  output logic [7:0]  pairs_sent
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND_A,
    SEND_B
  } state_t;

  state_t state;

  logic [63:0]   mem_a [FIFO_DEPTH];
  logic [63:0]   mem_b [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  logic [63:0] stage_a;
  logic [63:0] stage_b;
  logic [1:0]  dest_idx;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic last_dest;
  logic fin_pair;

  function automatic logic [3:0] dest_of(input logic [1:0] idx);
    logic [3:0] d;
    d = DEST0;
    unique case (idx)
      2'd0: d = DEST0;
      2'd1: d = DEST1;
      2'd2: d = DEST2;
      2'd3: d = DEST3;
    endcase
    return d;
  endfunction

  function automatic logic [70:0] mk_flit(
    input logic [3:0]  dest,
    input logic        vc,
    input logic [63:0] data
  );
    return {1'b1, 1'b1, dest, vc, data};
  endfunction

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  // Held low during reset so the producer never sees a ready it can't use.
  assign op_ready  = !reset && !full;
  assign push      = op_valid && op_ready;
  assign last_dest = (dest_idx == 2'(DEST_COUNT - 1));
  assign fin_pair  = (state == SEND_B) && send_accept && last_dest;

  // The FSM pops the head whenever it needs a fresh pair.
  assign pop = !reset && !empty &&
               ((state == IDLE) || fin_pair);

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage needs no reset; only pointers and count define contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= op_a;
      mem_b[wr_ptr] <= op_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      dest_idx     <= '0;
      stage_a      <= '0;
      stage_b      <= '0;
      ready_send   <= 1'b0;
      output_flit1 <= '0;
      pairs_sent   <= '0;
      busy         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            stage_a      <= mem_a[rd_ptr];
            stage_b      <= mem_b[rd_ptr];
            dest_idx     <= '0;
            output_flit1 <= mk_flit(dest_of(2'd0), 1'b0,
                                    mem_a[rd_ptr]);
            ready_send   <= 1'b1;
            state        <= SEND_A;
            busy         <= 1'b1;
          end else begin
            busy <= (count_nxt != '0);
          end
        end
        SEND_A: begin
          busy <= 1'b1;
          if (send_accept) begin
            output_flit1 <= mk_flit(dest_of(dest_idx), 1'b1,
                                    stage_b);
            state        <= SEND_B;
          end
        end
        SEND_B: begin
          busy <= 1'b1;
          if (send_accept) begin
            if (!last_dest) begin
              // Replay the staged pair to the next destination.
              dest_idx     <= dest_idx + 2'd1;
              output_flit1 <= mk_flit(dest_of(dest_idx + 2'd1),
                                      1'b0, stage_a);
              state        <= SEND_A;
            end else begin
              pairs_sent <= pairs_sent + 8'd1;
              if (!empty) begin
                // Back-to-back pairs: no idle bubble between them.
                stage_a      <= mem_a[rd_ptr];
                stage_b      <= mem_b[rd_ptr];
                dest_idx     <= '0;
                output_flit1 <= mk_flit(dest_of(2'd0), 1'b0,
                                        mem_a[rd_ptr]);
                state        <= SEND_A;
              end else begin
                ready_send   <= 1'b0;
                output_flit1 <= '0;
                state        <= IDLE;
                busy         <= (count_nxt != '0);
              end
            end
          end
        end
        default: begin
          state        <= IDLE;
          ready_send   <= 1'b0;
          output_flit1 <= '0;
          busy         <= (count_nxt != '0);
        end
      endcase
    end
  end

endmodule
